shift_register_frame: RTL and testbench

Parametrised bidirectional shift register with framed serial-to-parallel (collect) and parallel-to-serial (drain) modes, a bit counter and valid/ready handshakes on all four data interfaces. It is the next generation of the CRC datapath's single-bit-load shift register. It sits between the serial bit interface and the CRC/word logic, and guarantees that no bit is dropped or duplicated under back-pressure.

---
 rtl/shift_register_frame_if.sv | 28 ++
 rtl/shift_register_frame.sv | 112 +++++++++++
 tb/tb_shift_register_frame.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_register_frame_if.sv
// Handshake bundle for shift_register_frame: serial in/out bits and parallel in/out words.
// The slave modport is the shift register side; the master modport is its environment.
interface shift_register_frame_if #(
  parameter int WIDTH = 8
);
  logic             s_in_valid;
  logic             s_in_data;
  logic             s_in_ready;
  logic             p_out_valid;
  logic [WIDTH-1:0] p_out_data;
  logic             p_out_ready;
  logic             p_in_valid;
  logic [WIDTH-1:0] p_in_data;
  logic             p_in_ready;
  logic             s_out_valid;
  logic             s_out_data;
  logic             s_out_ready;

  modport master (
    output s_in_valid, s_in_data, p_out_ready, p_in_valid, p_in_data, s_out_ready,
    input  s_in_ready, p_out_valid, p_out_data, p_in_ready, s_out_valid, s_out_data
  );

  modport slave (
    input  s_in_valid, s_in_data, p_out_ready, p_in_valid, p_in_data, s_out_ready,
    output s_in_ready, p_out_valid, p_out_data, p_in_ready, s_out_valid, s_out_data
  );
endinterface

// File: rtl/shift_register_frame.sv
// Framed bidirectional shift register: collects serial bits into a word, or drains a word as bits.
// Optional macro SHIFT_REG_ROTATE_EN: drained bits rotate back in, so the loaded word survives a drain.
module shift_register_frame #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  dir,
  shift_register_frame_if.slave bus,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_reg;
  logic             dir_q;

  logic             out_bit;
  logic             fill;
  logic [WIDTH-1:0] first_in;
  logic [WIDTH-1:0] shifted_in;
  logic [WIDTH-1:0] shifted_out;

  assign out_bit = dir_q ? data_reg[0] : data_reg[WIDTH-1];

`ifdef SHIFT_REG_ROTATE_EN
  assign fill = out_bit;
`else
  assign fill = 1'b0;
`endif

  // The first bit of a frame uses the live dir input, since dir_q is only captured on that edge.
  assign first_in    = dir ? {bus.s_in_data, {(WIDTH-1){1'b0}}}
                           : {{(WIDTH-1){1'b0}}, bus.s_in_data};
  assign shifted_in  = dir_q ? {bus.s_in_data, data_reg[WIDTH-1:1]}
                             : {data_reg[WIDTH-2:0], bus.s_in_data};
  assign shifted_out = dir_q ? {fill, data_reg[WIDTH-1:1]}
                             : {data_reg[WIDTH-2:0], fill};

  assign bus.s_in_ready  = ((state == IDLE) && !bus.p_in_valid) || (state == COLLECT);
  assign bus.p_in_ready  = (state == IDLE);
  assign bus.p_out_valid = (state == FULL);
  assign bus.p_out_data  = data_reg;
  assign bus.s_out_valid = (state == DRAIN);
  assign bus.s_out_data  = out_bit;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= '0;
      bit_cnt  <= '0;
      dir_q    <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      data_reg <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.p_in_valid) begin
            data_reg <= bus.p_in_data;
            bit_cnt  <= CNT_W'(WIDTH);
            dir_q    <= dir;
            state    <= DRAIN;
          end else if (bus.s_in_valid) begin
            data_reg <= first_in;
            bit_cnt  <= CNT_W'(1);
            dir_q    <= dir;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.s_in_valid) begin
            data_reg <= shifted_in;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (bus.p_out_ready) begin
            data_reg <= '0;
            bit_cnt  <= '0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.s_out_ready) begin
            data_reg <= shifted_out;
            bit_cnt  <= bit_cnt - CNT_W'(1);
            if (bit_cnt == CNT_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register_frame.sv
// Directed bench for shift_register_frame (WIDTH=8): reset, collect in both directions,
// back-pressured drain, load/serial contention, clr and rst+clr.
module tb_shift_register_frame;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             dir;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_register_frame_if #(.WIDTH(WIDTH)) bus ();

  shift_register_frame #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .dir     (dir),
    .bus     (bus),
    .bit_cnt (bit_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of handshake inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic s_valid, input logic s_data, input logic p_ready,
                               input logic p_valid, input logic [WIDTH-1:0] p_data, input logic s_ready);
    bus.s_in_valid  = s_valid;
    bus.s_in_data   = s_data;
    bus.p_out_ready = p_ready;
    bus.p_in_valid  = p_valid;
    bus.p_in_data   = p_data;
    bus.s_out_ready = s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Sends bits 1,0,1,1,0,0,1,0 with idle gaps; optionally toggles dir mid-frame.
  task automatic sendFrame(input logic toggle_dir, input logic [WIDTH-1:0] expected_word);
    logic [WIDTH-1:0] bits;
    bits = 8'b1011_0010;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        checkOutput("pre_last_p_out_valid", 64'(bus.p_out_valid), 64'd0);
        checkOutput("pre_last_bit_cnt", 64'(bit_cnt), 64'd7);
      end
      applyStimulus(1'b1, bits[WIDTH-1-i], 1'b0, 1'b0, '0, 1'b0);
      if (toggle_dir) dir = ~dir;
      if ((i % 3 == 0) && (i < WIDTH - 1)) idleCycle();
    end
    checkOutput("word_p_out_valid", 64'(bus.p_out_valid), 64'd1);
    checkOutput("word_bit_cnt", 64'(bit_cnt), 64'd8);
    checkOutput("word_p_out_data", 64'(bus.p_out_data), 64'(expected_word));
  endtask

  task automatic drainFrame(input logic [WIDTH-1:0] word);
    int idx;
    idx = 0;
    for (int c = 0; c < 2 * WIDTH && idx < WIDTH; c++) begin
      checkOutput("drain_s_out_valid", 64'(bus.s_out_valid), 64'd1);
      checkOutput("drain_s_out_data", 64'(bus.s_out_data), 64'(word[WIDTH-1-idx]));
      checkOutput("drain_busy", 64'(busy), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, (c % 2 == 0));
      if (c % 2 == 0) idx++;
    end
    checkOutput("drain_done_count", 64'(idx), 64'd8);
    checkOutput("drain_end_busy", 64'(busy), 64'd0);
    checkOutput("drain_end_s_out_valid", 64'(bus.s_out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    dir = 1'b0;
    idleCycle();
    idleCycle();
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_bit_cnt", 64'(bit_cnt), 64'd0);
    checkOutput("reset_p_out_valid", 64'(bus.p_out_valid), 64'd0);
    checkOutput("reset_s_out_valid", 64'(bus.s_out_valid), 64'd0);
    checkOutput("reset_p_in_ready", 64'(bus.p_in_ready), 64'd1);

    // Reset in the middle of a collect
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("mid_collect_bit_cnt", 64'(bit_cnt), 64'd3);
    checkOutput("mid_collect_busy", 64'(busy), 64'd1);
    checkOutput("mid_collect_data", 64'(bus.p_out_data), 64'h05);
    rst = 1'b1;
    idleCycle();
    idleCycle();
    rst = 1'b0;
    checkOutput("midrst_bit_cnt", 64'(bit_cnt), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_p_out_valid", 64'(bus.p_out_valid), 64'd0);
    checkOutput("midrst_s_out_valid", 64'(bus.s_out_valid), 64'd0);
    checkOutput("midrst_s_in_ready", 64'(bus.s_in_ready), 64'd1);

    // MSB-first collect with a stalled consumer
    dir = 1'b0;
    sendFrame(1'b0, 8'hB2);
    for (int k = 0; k < 5; k++) begin
      idleCycle();
      checkOutput("stall_p_out_data", 64'(bus.p_out_data), 64'hB2);
      checkOutput("stall_s_in_ready", 64'(bus.s_in_ready), 64'd0);
      checkOutput("stall_s_out_valid", 64'(bus.s_out_valid), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("release_busy", 64'(busy), 64'd0);
    checkOutput("release_p_out_valid", 64'(bus.p_out_valid), 64'd0);
    checkOutput("release_p_out_data", 64'(bus.p_out_data), 64'h00);

    // LSB-first collect; dir toggles after every bit must not matter
    dir = 1'b1;
    sendFrame(1'b1, 8'h4D);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("lsb_release_busy", 64'(busy), 64'd0);

    // Parallel load and back-pressured MSB-first drain
    dir = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    checkOutput("load_bit_cnt", 64'(bit_cnt), 64'd8);
    drainFrame(8'hA5);
`ifdef SHIFT_REG_ROTATE_EN
    checkOutput("drain_final_data", 64'(bus.p_out_data), 64'hA5);
`else
    checkOutput("drain_final_data", 64'(bus.p_out_data), 64'h00);
`endif

    // Simultaneous parallel and serial requests in IDLE
    bus.s_in_valid = 1'b1;
    bus.s_in_data  = 1'b1;
    bus.p_in_valid = 1'b1;
    bus.p_in_data  = 8'h3C;
    #1;
    checkOutput("contend_s_in_ready", 64'(bus.s_in_ready), 64'd0);
    checkOutput("contend_p_in_ready", 64'(bus.p_in_ready), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    checkOutput("contend_s_out_valid", 64'(bus.s_out_valid), 64'd1);
    checkOutput("contend_data", 64'(bus.p_out_data), 64'h3C);
    checkOutput("contend_bit_cnt", 64'(bit_cnt), 64'd8);
    checkOutput("contend_first_bit", 64'(bus.s_out_data), 64'd0);
    for (int k = 0; k < WIDTH; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("contend_drained_busy", 64'(busy), 64'd0);

    // clr while FULL
    dir = 1'b0;
    sendFrame(1'b0, 8'hB2);
    clr = 1'b1;
    idleCycle();
    clr = 1'b0;
    checkOutput("clr_p_out_valid", 64'(bus.p_out_valid), 64'd0);
    checkOutput("clr_bit_cnt", 64'(bit_cnt), 64'd0);
    checkOutput("clr_p_out_data", 64'(bus.p_out_data), 64'h00);
    checkOutput("clr_busy", 64'(busy), 64'd0);

    // rst and clr together mid-drain
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("pre_rstclr_bit_cnt", 64'(bit_cnt), 64'd7);
    rst = 1'b1;
    clr = 1'b1;
    idleCycle();
    rst = 1'b0;
    clr = 1'b0;
    checkOutput("rstclr_busy", 64'(busy), 64'd0);
    checkOutput("rstclr_bit_cnt", 64'(bit_cnt), 64'd0);
    checkOutput("rstclr_data", 64'(bus.p_out_data), 64'h00);
    checkOutput("rstclr_s_out_valid", 64'(bus.s_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
